// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multi-cycle controller.
//   state_t    - FSM state code, also exported on the STATE debug output
//   Op*/Fn*    - opcode and R-type funct field values
//   Alu*       - ALU_OP codes
//   SrcB*      - ALU_SRC_B operand selects
//   PcSrc*     - PC_SRC selects
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIf   = 4'd0;
  localparam state_t StId   = 4'd1;
  localparam state_t StExr  = 4'd2;
  localparam state_t StExi  = 4'd3;
  localparam state_t StAddr = 4'd4;
  localparam state_t StMrd  = 4'd5;
  localparam state_t StMwr  = 4'd6;
  localparam state_t StWbr  = 4'd7;
  localparam state_t StWbi  = 4'd8;
  localparam state_t StWbm  = 4'd9;
  localparam state_t StBr   = 4'd10;
  localparam state_t StJmp  = 4'd11;
  localparam state_t StErr  = 4'd12;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // States that sit on the MEM_READY handshake and run the wait counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == StIf) || (s == StMrd) || (s == StMwr);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU operation decode.
//   op_i     - instruction opcode
//   funct_i  - R-type funct field
//   alu_op_o - ALU operation code for the execute step of this instruction
//   ill_o    - opcode not supported, or R-type with an unsupported funct
// Optional feature macro: MC_CONTROL_BNE_EN (bne decodes as a subtract).
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       ill_o
);

  always_comb begin
    alu_op_o = AluAdd;
    ill_o    = 1'b0;
    case (op_i)
      OpRtype: begin
        case (funct_i)
          FnAdd:   alu_op_o = AluAdd;
          FnSub:   alu_op_o = AluSub;
          FnAnd:   alu_op_o = AluAnd;
          FnOr:    alu_op_o = AluOr;
          FnSlt:   alu_op_o = AluSlt;
          default: ill_o    = 1'b1;
        endcase
      end
      OpAddi, OpLw, OpSw, OpJ: alu_op_o = AluAdd;
      OpAndi:                  alu_op_o = AluAnd;
      OpOri:                   alu_op_o = AluOr;
      OpBeq:                   alu_op_o = AluSub;
`ifdef MC_CONTROL_BNE_EN
      OpBne:                   alu_op_o = AluSub;
`endif
      default:                 ill_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle processor control FSM with memory handshake timeout.
//   CLK, RST           - clock, asynchronous active-high reset
//   OP, FUNCT          - instruction register fields
//   ZERO               - ALU zero flag (branch condition)
//   MEM_READY          - memory handshake completion
//   PC_WE, IR_WE, REG_WE, MEM_RD, MEM_WR, IORD, REG_DST, MEM_TO_REG, ALU_SRC_A, EXT_S,
//   ALU_SRC_B, ALU_OP, PC_SRC - datapath controls
//   ILL                - one-cycle illegal instruction pulse
//   BUS_ERR            - sticky memory timeout flag (cleared only by RST)
//   STATE              - current FSM state (debug)
// Optional feature macro: MC_CONTROL_BNE_EN adds bne (OP=0x05, branch on ~ZERO).
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OP,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       PC_WE,
  output logic       IR_WE,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       IORD,
  output logic       REG_WE,
  output logic       REG_DST,
  output logic       MEM_TO_REG,
  output logic       ALU_SRC_A,
  output logic       ILL,
  output logic       BUS_ERR,
  output logic       EXT_S,
  output logic [1:0] ALU_SRC_B,
  output logic [3:0] ALU_OP,
  output logic [1:0] PC_SRC,
  output logic [3:0] STATE
);

  // cnt_q holds the number of MEM_READY-low cycles already spent in the current wait
  // state, so it equals MEM_TIMEOUT-1 in the last cycle that may still succeed.
  localparam int unsigned    CntW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      dec_alu_op;
  logic            dec_ill;
  logic            timeout;

  mc_alu_dec u_alu_dec (
    .op_i     (OP),
    .funct_i  (FUNCT),
    .alu_op_o (dec_alu_op),
    .ill_o    (dec_ill)
  );

  assign timeout = !MEM_READY && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIf: begin
        if (MEM_READY)    state_d = StId;
        else if (timeout) state_d = StErr;
      end
      StId: begin
        case (OP)
          OpRtype:               state_d = StExr;
          OpAddi, OpAndi, OpOri: state_d = StExi;
          OpLw, OpSw:            state_d = StAddr;
          OpBeq:                 state_d = StBr;
`ifdef MC_CONTROL_BNE_EN
          OpBne:                 state_d = StBr;
`endif
          OpJ:                   state_d = StJmp;
          default:               state_d = StIf;
        endcase
      end
      StExr:  state_d = dec_ill ? StIf : StWbr;
      StExi:  state_d = StWbi;
      StAddr: state_d = (OP == OpLw) ? StMrd : StMwr;
      StMrd: begin
        if (MEM_READY)    state_d = StWbm;
        else if (timeout) state_d = StErr;
      end
      StMwr: begin
        if (MEM_READY)    state_d = StIf;
        else if (timeout) state_d = StErr;
      end
      StWbr, StWbi, StWbm, StBr, StJmp: state_d = StIf;
      StErr:   state_d = StErr;
      default: state_d = StIf;
    endcase
  end

  // Any state change restarts the count, which covers every entry into a wait state.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (is_wait_state(state_q)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PC_WE      = 1'b0;
    IR_WE      = 1'b0;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    IORD       = 1'b0;
    REG_WE     = 1'b0;
    REG_DST    = 1'b0;
    MEM_TO_REG = 1'b0;
    ALU_SRC_A  = 1'b0;
    ILL        = 1'b0;
    BUS_ERR    = 1'b0;
    EXT_S      = 1'b0;
    ALU_SRC_B  = SrcBReg;
    ALU_OP     = AluAdd;
    PC_SRC     = PcSrcAlu;
    // RST gates the outputs combinationally so nothing pulses while it is high.
    if (!RST) begin
      case (state_q)
        StIf: begin
          MEM_RD    = 1'b1;
          ALU_SRC_B = SrcBFour;
          IR_WE     = MEM_READY;
          PC_WE     = MEM_READY;
        end
        StId: begin
          ALU_SRC_B = SrcBImmSh2;
          EXT_S     = 1'b1;
          ILL       = (state_d == StIf);
        end
        StExr: begin
          ALU_SRC_A = 1'b1;
          ALU_OP    = dec_alu_op;
          ILL       = dec_ill;
        end
        StExi: begin
          ALU_SRC_A = 1'b1;
          ALU_SRC_B = SrcBImm;
          ALU_OP    = dec_alu_op;
          EXT_S     = (OP == OpAddi);
        end
        StAddr: begin
          ALU_SRC_A = 1'b1;
          ALU_SRC_B = SrcBImm;
          ALU_OP    = dec_alu_op;
          EXT_S     = 1'b1;
        end
        StMrd: begin
          MEM_RD = 1'b1;
          IORD   = 1'b1;
        end
        StMwr: begin
          MEM_WR = 1'b1;
          IORD   = 1'b1;
        end
        StWbr: begin
          REG_WE  = 1'b1;
          REG_DST = 1'b1;
        end
        StWbi: REG_WE = 1'b1;
        StWbm: begin
          REG_WE     = 1'b1;
          MEM_TO_REG = 1'b1;
        end
        StBr: begin
          ALU_SRC_A = 1'b1;
          ALU_OP    = AluSub;
          PC_SRC    = PcSrcAluOut;
`ifdef MC_CONTROL_BNE_EN
          PC_WE     = (OP == OpBne) ? !ZERO : ZERO;
`else
          PC_WE     = ZERO;
`endif
        end
        StJmp: begin
          PC_SRC = PcSrcJump;
          PC_WE  = 1'b1;
        end
        StErr:   BUS_ERR = 1'b1;
        default: ;
      endcase
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control. For each instruction the bench derives the expected
// per-cycle control vector from the instruction's class and handshake delays, queues it,
// and a single negedge process compares the DUT against the queue.
module tb_mc_control;

  localparam int unsigned TO = 15;
`ifdef MC_CONTROL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, ZERO, MEM_READY;
  logic [5:0] OP, FUNCT;
  logic       PC_WE, IR_WE, MEM_RD, MEM_WR, IORD, REG_WE, REG_DST, MEM_TO_REG;
  logic       ALU_SRC_A, ILL, BUS_ERR, EXT_S;
  logic [1:0] ALU_SRC_B, PC_SRC;
  logic [3:0] ALU_OP, STATE;

  mc_control #(.MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .OP(OP), .FUNCT(FUNCT), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .PC_WE(PC_WE), .IR_WE(IR_WE), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IORD(IORD),
    .REG_WE(REG_WE), .REG_DST(REG_DST), .MEM_TO_REG(MEM_TO_REG), .ALU_SRC_A(ALU_SRC_A),
    .ILL(ILL), .BUS_ERR(BUS_ERR), .EXT_S(EXT_S), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
    .PC_SRC(PC_SRC), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg;
    logic       alu_src_a, ill, bus_err, ext_s;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_src;
    logic       in_if;  // STATE reads as the fetch code 0
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0, n_errors = 0;
  int    cyc = 0, last_ir = 0, gap = 0, if_run = 0, if_len = 0;

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.alu_op = 4'b0010;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a = {PC_WE, IR_WE, MEM_RD, MEM_WR, IORD, REG_WE, REG_DST, MEM_TO_REG,
         ALU_SRC_A, ILL, BUS_ERR, EXT_S, ALU_SRC_B, ALU_OP, PC_SRC, (STATE == 4'd0)};
    return a;
  endfunction

  // Single compare process; also measures fetch-to-fetch distance and fetch length.
  always @(negedge CLK) begin : compare
    exp_t  e, a;
    string nm;
    if (!RST) begin
      cyc++;
      if (STATE == 4'd0) if_run++;
      else if_run = 0;
      if (IR_WE === 1'b1) begin
        if_len  = if_run;
        gap     = cyc - last_ir;
        last_ir = cyc;
      end
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = actual();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s (cycle %0d): got %h required %h", nm, cyc, a, e);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Called at posedge+1; queues one cycle's expectation and advances to the next posedge+1.
  task automatic tick(input string nm, input exp_t e, input logic rdy);
    MEM_READY = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  task automatic err_hold(input string nm);
    exp_t e;
    e = blank();
    e.bus_err = 1'b1;
    for (int i = 0; i < 3; i++) tick({nm, "/err"}, e, (i % 2 == 0));
  endtask

  // wait_n low cycles then ready; TO consecutive low cycles end in the error state.
  task automatic handshake(input string nm, input exp_t w, input exp_t go, input int wait_n,
                           output bit err);
    int lows;
    lows = (wait_n < int'(TO)) ? wait_n : int'(TO);
    for (int i = 0; i < lows; i++) tick(nm, w, 1'b0);
    err = (wait_n >= int'(TO));
    if (!err) tick(nm, go, 1'b1);
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int if_wait, input int mem_wait,
                           input bit stop_before_mem);
    exp_t e, g;
    bit   err, legal;
    OP = op; FUNCT = fn; ZERO = z;
    e = blank(); e.mem_rd = 1'b1; e.alu_src_b = 2'b01; e.in_if = 1'b1;
    g = e; g.ir_we = 1'b1; g.pc_we = 1'b1;
    handshake({nm, "/fetch"}, e, g, if_wait, err);
    if (err) begin err_hold(nm); return; end
    legal = (op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B}) ||
            (BneEn && op == 6'h05);
    e = blank(); e.alu_src_b = 2'b11; e.ext_s = 1'b1; e.ill = !legal;
    tick({nm, "/decode"}, e, 1'b1);
    if (!legal) return;
    if (op == 6'h00) begin
      e = blank(); e.alu_src_a = 1'b1;
      case (fn)
        6'h20:   e.alu_op = 4'b0010;
        6'h22:   e.alu_op = 4'b0110;
        6'h24:   e.alu_op = 4'b0000;
        6'h25:   e.alu_op = 4'b0001;
        6'h2A:   e.alu_op = 4'b0111;
        default: e.ill = 1'b1;
      endcase
      tick({nm, "/exec"}, e, 1'b1);
      if (e.ill) return;
      e = blank(); e.reg_we = 1'b1; e.reg_dst = 1'b1;
      tick({nm, "/wb"}, e, 1'b1);
    end else if (op inside {6'h08, 6'h0C, 6'h0D}) begin
      e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ext_s = (op == 6'h08);
      e.alu_op = (op == 6'h08) ? 4'b0010 : (op == 6'h0C) ? 4'b0000 : 4'b0001;
      tick({nm, "/exec"}, e, 1'b1);
      e = blank(); e.reg_we = 1'b1;
      tick({nm, "/wb"}, e, 1'b1);
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ext_s = 1'b1;
      tick({nm, "/addr"}, e, 1'b1);
      if (stop_before_mem) return;
      e = blank(); e.iord = 1'b1;
      if (op == 6'h23) e.mem_rd = 1'b1;
      else e.mem_wr = 1'b1;
      handshake({nm, "/mem"}, e, e, mem_wait, err);
      if (err) begin err_hold(nm); return; end
      if (op == 6'h23) begin
        e = blank(); e.reg_we = 1'b1; e.mem_to_reg = 1'b1;
        tick({nm, "/wb"}, e, 1'b1);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e = blank(); e.alu_src_a = 1'b1; e.alu_op = 4'b0110; e.pc_src = 2'b01;
      e.pc_we = (op == 6'h05) ? !z : z;
      tick({nm, "/branch"}, e, 1'b1);
    end else begin
      e = blank(); e.pc_src = 2'b10; e.pc_we = 1'b1;
      tick({nm, "/jump"}, e, 1'b1);
    end
  endtask

  // Reset outputs: all 1-bit 0, ALU_SRC_B=00, ALU_OP=0010, PC_SRC=00, STATE=0.
  task automatic check_rst(input string nm);
    logic [23:0] v;
    v = {PC_WE, IR_WE, MEM_RD, MEM_WR, IORD, REG_WE, REG_DST, MEM_TO_REG,
         ALU_SRC_A, ILL, BUS_ERR, EXT_S, ALU_SRC_B, ALU_OP, PC_SRC, STATE};
    check(nm, 32'(v), 32'h0000_0080);
  endtask

  task automatic do_reset(input string nm);
    RST = 1'b1;
    #1;
    check_rst({nm, "/immediate"});
    @(posedge CLK);
    #1;
    check_rst({nm, "/held"});
    MEM_READY = 1'b1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ZERO = 1'b0; MEM_READY = 1'b0; OP = 6'h00; FUNCT = 6'h20;
    @(posedge CLK);
    #1;
    do_reset("por");

    run_instr("lw", 6'h23, 6'h00, 1'b0, 3, 0, 1'b0);
    check("lw_fetch_cycles", 32'(if_len), 32'd4);
    run_instr("ori", 6'h0D, 6'h00, 1'b0, 0, 0, 1'b0);
    check("lw_len", 32'(gap), 32'd5);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    check("ori_len", 32'(gap), 32'd4);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
    check("beq_taken_len", 32'(gap), 32'd3);
    run_instr("j", 6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    check("beq_not_taken_len", 32'(gap), 32'd3);
    run_instr("sw", 6'h2B, 6'h00, 1'b0, 0, 0, 1'b0);
    check("j_len", 32'(gap), 32'd3);
    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
    check("sw_len", 32'(gap), 32'd4);
    run_instr("sub", 6'h00, 6'h22, 1'b1, 0, 0, 1'b0);
    check("add_len", 32'(gap), 32'd4);
    run_instr("and", 6'h00, 6'h24, 1'b0, 0, 0, 1'b0);
    run_instr("or", 6'h00, 6'h25, 1'b0, 0, 0, 1'b0);
    run_instr("slt", 6'h00, 6'h2A, 1'b0, 0, 0, 1'b0);
    run_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("andi", 6'h0C, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("ill_op", 6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("ill_funct", 6'h00, 6'h00, 1'b0, 0, 0, 1'b0);
    check("ill_op_len", 32'(gap), 32'd2);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0, 1'b0);
    check("ill_funct_len", 32'(gap), 32'd3);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, 1'b0);
    run_instr("lw_wait14", 6'h23, 6'h00, 1'b0, 0, 14, 1'b0);
    run_instr("addi_fetch14", 6'h08, 6'h00, 1'b0, 14, 0, 1'b0);
    check("fetch14_cycles", 32'(if_len), 32'd15);

    run_instr("lw_cut", 6'h23, 6'h00, 1'b0, 0, 0, 1'b1);
    do_reset("rst_mid");
    run_instr("add_after_mid", 6'h00, 6'h20, 1'b0, 0, 0, 1'b0);

    run_instr("sw_timeout", 6'h2B, 6'h00, 1'b0, 0, 15, 1'b0);
    check("bus_err_sticky", 32'(BUS_ERR), 32'd1);
    do_reset("rst_err");
    run_instr("or_after_err", 6'h00, 6'h25, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum number of cycles to wait for MEM_READY before a bus error is flagged.
REQ-002 CLK  in  1  single system clock; all state changes on the rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 OP  in  6  opcode field of the instruction register.
REQ-005 FUNCT  in  6  funct field of the instruction register.
REQ-006 ZERO  in  1  ALU zero flag.
REQ-007 MEM_READY  in  1  memory handshake completion.
REQ-008 Outputs, 1 bit each: PC_WE, IR_WE, MEM_RD, MEM_WR, IORD, REG_WE, REG_DST, MEM_TO_REG, ALU_SRC_A, ILL, BUS_ERR.
REQ-009 EXT_S  out  1  sign-select for the 16-to-32 extender; 1 = sign-extend, 0 = zero-extend.
REQ-010 Further outputs:
- ALU_SRC_B  out  2  ALU B-operand select: 00 = reg, 01 = const 4, 10 = extended imm, 11 = extended imm shifted left 2.
- ALU_OP  out  4  ALU operation code.
- PC_SRC  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- STATE  out  4  current FSM state, for debug.

Function
REQ-011 The FSM shall use the states IF, ID, EXR, EXI, ADDR, MRD, MWR, WBR, WBI, WBM, BR, JMP and ERR.
REQ-012 In IF, the block shall hold MEM_RD=1 and IORD=0 until MEM_READY=1; in that cycle it shall pulse IR_WE=1 and PC_WE=1 with ALU_SRC_B=01, ALU_OP=add and PC_SRC=00, then go to ID.
REQ-013 In ID, the block shall compute the branch target (ALU_SRC_A=0, ALU_SRC_B=11, EXT_S=1, ALU_OP=add) and dispatch on OP:
- 0x00 → EXR
- 0x08, 0x0C, 0x0D → EXI
- 0x23, 0x2B → ADDR
- 0x04 → BR
- 0x02 → JMP
- any other → IF with ILL pulsed high for 1 cycle.
REQ-014 EXR shall decode FUNCT as follows, then go to WBR:
- 0x20 → add 0010
- 0x22 → sub 0110
- 0x24 → and 0000
- 0x25 → or 0001
- 0x2A → slt 0111
- any other → ILL pulsed high and return to IF, with no register write.
REQ-015 EXI shall use ALU_SRC_B=10 and then go to WBI, with:
- addi: EXT_S=1, add
- andi: EXT_S=0, and
- ori: EXT_S=0, or
REQ-016 ADDR shall use EXT_S=1, ALU_SRC_B=10 and add, then go to MRD for lw or MWR for sw.
REQ-017 MRD and MWR shall hold MEM_RD or MEM_WR respectively, with IORD=1, until MEM_READY=1, then go to WBM or IF respectively.
REQ-018 WBR shall assert REG_WE=1 and REG_DST=1; WBI shall assert REG_WE=1 and REG_DST=0; WBM shall assert REG_WE=1, REG_DST=0 and MEM_TO_REG=1; each returns to IF.
REQ-019 BR shall apply sub, PC_SRC=01 and PC_WE=ZERO, then return to IF.
REQ-020 JMP shall apply PC_SRC=10 and PC_WE=1, then return to IF.
REQ-021 With MEM_READY=1 throughout, the cycle counts shall be: R-type/addi/andi/ori/sw 4, lw 5, beq/j 3.
REQ-022 The control outputs shall be a Moore function of the state, except for handshake-qualified IR_WE/PC_WE, PC_WE in BR, and ILL.
REQ-023 The wait counter shall reset on every entry to IF, MRD or MWR.
REQ-024 If MEM_READY stays low for MEM_TIMEOUT consecutive cycles, the FSM shall enter ERR.
REQ-025 ERR shall hold BUS_ERR=1 with all write enables and memory strobes at 0 until reset.
REQ-026 MEM_READY=1 in the cycle the counter reaches MEM_TIMEOUT shall count as success, not error.
REQ-027 Outside their active states, all write enables and memory strobes shall be 0.

Reset
REQ-028 RST=1 shall immediately force state IF, clear the wait counter, and drive all 1-bit outputs to 0, ALU_SRC_B=00, ALU_OP=0010, PC_SRC=00 and STATE=0.
REQ-029 Reset asserted mid-instruction or in ERR shall abandon the operation with no further write pulse; after release, the block shall fetch on the first rising edge.

Configuration
REQ-030 When macro MC_CONTROL_BNE_EN is defined, OP=0x05 (bne) shall dispatch to BR with PC_WE=~ZERO.
REQ-031 When MC_CONTROL_BNE_EN is undefined, OP=0x05 shall be illegal (ILL pulse, return to IF).

Structure
REQ-032 Package mc_pkg shall hold the state encodings, the opcode/funct constants, the ALU_OP codes, and the ALU_SRC_B/PC_SRC select codes.
REQ-033 Sub-module mc_alu_dec shall perform the combinational FUNCT/OP→ALU_OP decode with its illegal flag; the FSM and wait counter stay in mc_control.

Verification
REQ-034 lw (OP=0x23), MEM_READY delayed 3 cycles in IF and 0 in MRD → IR_WE at cycle 4, WBM with MEM_TO_REG=1 reached, EXT_S=1 in ADDR.
REQ-035 ori (OP=0x0D) → EXT_S=0 and ALU_SRC_B=10 in EXI, REG_WE=1 with REG_DST=0 in WBI, 4 cycles total.
REQ-036 beq with ZERO=1, then with ZERO=0 → PC_WE=1 with PC_SRC=01, then PC_WE=0; 3 cycles each.
REQ-037 OP=0x3F, then R-type with FUNCT=0x00 → one-cycle ILL pulse each, REG_WE never asserted, next state IF.
REQ-038 MEM_READY held 0 in MWR (sw), MEM_TIMEOUT=15 → ERR after 15 wait cycles, BUS_ERR=1 sticky; RST pulse → STATE=IF, BUS_ERR=0.
REQ-039 With MC_CONTROL_BNE_EN defined, OP=0x05 and ZERO=0 → PC_WE=1 in BR; with the macro undefined → ILL.
